// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one Adder counter between NREQ requesters.
// Each grant issues a single inc/clr pulse and returns the updated count tagged with the requester id.
module adder_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_clr,
  output logic [NREQ-1:0]  req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             add_inc,
  output logic             add_clr,
  input  logic [WIDTH-1:0] add_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             inc_q, inc_d;
  logic             clr_q, clr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic             found;
  logic [IDW-1:0]   winner;

  // First valid requester strictly after the last winner, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    inc_d        = 1'b0;
    clr_d        = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    req_ready    = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          ptr_d             = winner;
          id_d              = winner;
          // Pulse registers are loaded here so they are high exactly during ISSUE.
          clr_d             = req_clr[winner];
          inc_d             = !req_clr[winner];
          state_d           = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        resp_data_d  = add_out;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= StIdle;
      ptr_q        <= IDW'(NREQ - 1);
      id_q         <= '0;
      inc_q        <= 1'b0;
      clr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      inc_q        <= inc_d;
      clr_q        <= clr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign add_inc    = inc_q;
  assign add_clr    = clr_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural Adder counter attached.
// Inputs are driven and outputs sampled around the falling edge.
module tb_adder_arbiter;

  logic       aclk;
  logic       arstn;
  logic [3:0] req_valid;
  logic [3:0] req_clr;
  logic [3:0] req_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [7:0] resp_data;
  logic       add_inc;
  logic       add_clr;
  logic [7:0] add_out;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(
    .NREQ (4),
    .WIDTH(8)
  ) dut (
    .aclk      (aclk),
    .arstn     (arstn),
    .req_valid (req_valid),
    .req_clr   (req_clr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .add_inc   (add_inc),
    .add_clr   (add_clr),
    .add_out   (add_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Adder: registered counter, clear has priority, wraps naturally.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) add_out <= '0;
    else if (add_clr) add_out <= '0;
    else if (add_inc) add_out <= add_out + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at negedge+1; polls a bounded number of cycles for resp_valid.
  task automatic wait_resp();
    int n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge aclk); #1;
      n++;
    end
    check("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  // Full cycle-by-cycle check of one op issued from IDLE.
  task automatic do_op_checked(input int id, input logic clr, input logic [7:0] exp_data);
    @(negedge aclk);
    req_valid  = 4'(1 << id);
    req_clr    = 4'(clr) << id;
    resp_ready = 1'b1;
    #1 check("c0_ready", 32'(req_ready), 32'(4'(1 << id)));
    check("c0_no_pulse", 32'({add_inc, add_clr}), 32'd0);
    @(negedge aclk);
    req_valid = '0;
    req_clr   = '0;
    #1 check("c1_pulse", 32'({add_inc, add_clr}), 32'({!clr, clr}));
    check("c1_ready", 32'(req_ready), 32'd0);
    @(negedge aclk); #1;
    check("c2_quiet", 32'({add_inc, add_clr, resp_valid}), 32'd0);
    @(negedge aclk); #1;
    check("c3_valid", 32'(resp_valid), 32'd1);
    check("c3_id", 32'(resp_id), 32'(id));
    check("c3_data", 32'(resp_data), 32'(exp_data));
    @(negedge aclk); #1;
    check("c4_valid_low", 32'(resp_valid), 32'd0);
  endtask

  task automatic run_op(input int id, input logic clr, output logic [7:0] data);
    int n = 0;
    @(negedge aclk);
    req_valid  = 4'(1 << id);
    req_clr    = 4'(clr) << id;
    resp_ready = 1'b1;
    #1;
    while (req_ready[id[1:0]] !== 1'b1 && n < 20) begin
      @(negedge aclk); #1;
      n++;
    end
    @(negedge aclk);
    req_valid = '0;
    req_clr   = '0;
    #1 wait_resp();
    data = resp_data;
    @(negedge aclk); #1;
  endtask

  logic [7:0] d;

  initial begin
    arstn      = 1'b0;
    req_valid  = '0;
    req_clr    = '0;
    resp_ready = 1'b0;

    // 1: reset
    #50;
    check("rst_outputs", 32'({req_ready, resp_valid, resp_id, resp_data, add_inc, add_clr}), 32'd0);
    #50 arstn = 1'b1;
    #1 check("rst_release", 32'({req_ready, resp_valid, resp_id, resp_data}), 32'd0);

    // 2: single increment from requester 2
    do_op_checked(2, 1'b0, 8'd1);

    // 3: round robin from a fresh reset
    @(negedge aclk);
    arstn = 1'b0;
    @(negedge aclk);
    arstn = 1'b1;
    req_valid  = 4'hF;
    req_clr    = '0;
    resp_ready = 1'b1;
    #1 check("rr_first_grant", 32'(req_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      wait_resp();
      check("rr_id", 32'(resp_id), 32'(k % 4));
      check("rr_data", 32'(resp_data), 32'(k + 1));
      if (k == 4) req_valid = '0;
      @(negedge aclk); #1;
    end
    check("rr_idle_no_grant", 32'(req_ready), 32'd0);

    // 4: clear from requester 1
    do_op_checked(1, 1'b1, 8'd0);

    // 5: backpressure
    @(negedge aclk);
    resp_ready = 1'b0;
    req_valid  = 4'b1000;
    #1 check("bp_accept", 32'(req_ready), 32'h8);
    @(negedge aclk);
    req_valid = 4'b0101;
    #1 wait_resp();
    check("bp_id", 32'(resp_id), 32'd3);
    check("bp_data", 32'(resp_data), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk); #1;
      check("bp_hold", 32'({resp_valid, resp_id, resp_data}), 32'({1'b1, 2'd3, 8'd1}));
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge aclk); #1;
    check("bp_valid_drop", 32'(resp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'h1);
    @(negedge aclk);
    req_valid = '0;
    #1 check("bp_single_accept", 32'(req_ready), 32'd0);
    wait_resp();
    check("bp_next_id", 32'(resp_id), 32'd0);
    check("bp_next_data", 32'(resp_data), 32'd2);
    @(negedge aclk); #1;

    // 6a: wrap-around
    run_op(0, 1'b1, d);
    check("wrap_clear", 32'(d), 32'd0);
    for (int k = 0; k < 255; k++) run_op(k % 4, 1'b0, d);
    check("wrap_max", 32'(d), 32'd255);
    run_op(1, 1'b0, d);
    check("wrap_zero", 32'(d), 32'd0);
    check("wrap_id", 32'(resp_id), 32'd1);

    // 6b: reset during WAIT
    @(negedge aclk);
    req_valid = 4'b0100;
    #1 check("mid_accept", 32'(req_ready), 32'h4);
    @(negedge aclk);
    req_valid = '0;
    @(negedge aclk);
    arstn = 1'b0;
    #1 check("mid_rst_out", 32'({resp_valid, resp_id, resp_data, add_inc, add_clr}), 32'd0);
    repeat (3) @(negedge aclk);
    arstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk); #1;
      check("mid_no_resp", 32'({resp_valid, req_ready, add_inc, add_clr}), 32'd0);
    end
    req_valid = 4'hF;
    #1 check("mid_ptr_reset", 32'(req_ready), 32'h1);
    @(negedge aclk);
    req_valid = '0;
    #1 wait_resp();
    check("mid_after_id", 32'(resp_id), 32'd0);
    check("mid_after_data", 32'(resp_data), 32'd1);
    @(negedge aclk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
